// File: rtl/alu_seq_pkg.sv
// Shared encodings for the ALU command/response sequencer: op codes,
// FSM state type and response flag bit positions.
package alu_seq_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_CMP = 2'b10;
  localparam logic [1:0] OP_AND = 2'b11;

  localparam int FLG_EQ = 2;
  localparam int FLG_GT = 1;
  localparam int FLG_LT = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } state_t;

endpackage

// File: rtl/alu_seq_ctrl.sv
// Command/response sequencer around the combinational 4-bit ALU: holds operands
// and selects stable for SETTLE_CYCLES, then captures and normalises the result.
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,  // legal range 1..15
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [3:0]       cmd_a,
  input  logic [3:0]       cmd_b,
  output logic             alu_select0,
  output logic             alu_select1,
  output logic [3:0]       alu_bit1,
  output logic [3:0]       alu_bit2,
  input  logic [4:0]       alu_result1,
  input  logic [4:0]       alu_result2,
  input  logic             alu_equal,
  input  logic             alu_greater,
  input  logic             alu_lesser,
  input  logic [4:0]       alu_result4,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [1:0]       rsp_op,
  output logic [4:0]       rsp_data,
  output logic [2:0]       rsp_flags,
  output logic             busy,
  output logic [CNT_W-1:0] ops_done,
  output state_t           dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // The producer holds valid and payload stable until that edge; ready
  // never depends combinationally on the other side's valid/ready.

  localparam logic [3:0]       SETTLE_INIT = 4'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state, state_nxt;
  logic [3:0]       cnt_q;
  logic [1:0]       drv_op_q;
  logic [3:0]       drv_a_q, drv_b_q;
  logic             rsp_valid_q;
  logic [1:0]       rsp_op_q;
  logic [4:0]       rsp_data_q;
  logic [2:0]       rsp_flags_q;
  logic [CNT_W-1:0] ops_done_q;

  logic             accept, capture, rsp_hs;
  logic [4:0]       cap_data;
  logic [2:0]       cap_flags;

  // Bit 4 of the subtractor and AND outputs is not driven by the ALU.
  logic unused_alu_bits;
  assign unused_alu_bits = alu_result2[4] ^ alu_result4[4];

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    capture   = 1'b0;
    rsp_hs    = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          accept    = 1'b1;
          state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == 4'd0) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (rsp_valid_q && rsp_ready) begin
          rsp_hs    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Borrow comes from the latched operands; the ALU's bit 4 is meaningless here.
  always_comb begin
    cap_data  = 5'd0;
    cap_flags = 3'b000;
    case (drv_op_q)
      OP_ADD: cap_data = alu_result1;
      OP_SUB: cap_data = {(drv_a_q < drv_b_q), alu_result2[3:0]};
      OP_CMP: begin
        cap_flags[FLG_EQ] = alu_equal;
        cap_flags[FLG_GT] = alu_greater;
        cap_flags[FLG_LT] = alu_lesser;
      end
      default: cap_data = {1'b0, alu_result4[3:0]};
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q       <= 4'd0;
      drv_op_q    <= 2'b00;
      drv_a_q     <= 4'd0;
      drv_b_q     <= 4'd0;
      rsp_valid_q <= 1'b0;
      rsp_op_q    <= 2'b00;
      rsp_data_q  <= 5'd0;
      rsp_flags_q <= 3'b000;
      ops_done_q  <= '0;
    end else begin
      if (accept) begin
        drv_op_q <= cmd_op;
        drv_a_q  <= cmd_a;
        drv_b_q  <= cmd_b;
        cnt_q    <= SETTLE_INIT;
      end else if (state == SETTLE && cnt_q != 4'd0) begin
        cnt_q <= cnt_q - 4'd1;
      end
      // The ALU is parked at op 00 with zero operands outside an operation.
      if (capture) begin
        rsp_valid_q <= 1'b1;
        rsp_op_q    <= drv_op_q;
        rsp_data_q  <= cap_data;
        rsp_flags_q <= cap_flags;
        drv_op_q    <= 2'b00;
        drv_a_q     <= 4'd0;
        drv_b_q     <= 4'd0;
      end
      if (rsp_hs) begin
        rsp_valid_q <= 1'b0;
        ops_done_q  <= ops_done_q + CNT_ONE;
      end
    end
  end

  // A comparator must report exactly one relation; this is not corrected.
  always_ff @(posedge clk) begin
    if (rst_n && capture && drv_op_q == OP_CMP)
      assert ($onehot({alu_equal, alu_greater, alu_lesser}));
  end

  assign cmd_ready   = (state == IDLE);
  assign busy        = (state != IDLE);
  assign dbg_state   = state;
  assign alu_select0 = drv_op_q[0];
  assign alu_select1 = drv_op_q[1];
  assign alu_bit1    = drv_a_q;
  assign alu_bit2    = drv_b_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_op      = rsp_op_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_flags   = rsp_flags_q;
  assign ops_done    = ops_done_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: two instances (settle 1 and 3), each fed by a
// behavioural ALU, checked against an expected-response queue.
module tb_alu_seq_ctrl;
  import alu_seq_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [9:0] exp_q[$];   // {op, data, flags}
  logic [7:0] exp_ops1, exp_ops3;

  // ---------------- shared command payload ----------------
  logic [1:0] cmd_op;
  logic [3:0] cmd_a, cmd_b;

  // ---------------- instance 1: SETTLE_CYCLES = 1 ----------------
  logic       rst_n1, cmd_valid1, cmd_ready1, rsp_ready1;
  logic       sel0_1, sel1_1, eq1, gt1, lt1, rsp_valid1, busy1;
  logic [3:0] bit1_1, bit2_1;
  logic [4:0] res1_1, res2_1, res4_1, rsp_data1;
  logic [1:0] rsp_op1;
  logic [2:0] rsp_flags1;
  logic [7:0] ops_done1;
  state_t     dbg_state1;

  assign res1_1 = {1'b0, bit1_1} + {1'b0, bit2_1};
  assign res2_1 = {1'bx, 4'(bit1_1 - bit2_1)};
  assign res4_1 = {1'bx, bit1_1 & bit2_1};
  assign eq1    = (bit1_1 == bit2_1);
  assign gt1    = (bit1_1 >  bit2_1);
  assign lt1    = (bit1_1 <  bit2_1);

  alu_seq_ctrl #(.SETTLE_CYCLES(1), .CNT_W(8)) u_dut1 (
    .clk(clk), .rst_n(rst_n1), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_select0(sel0_1), .alu_select1(sel1_1), .alu_bit1(bit1_1), .alu_bit2(bit2_1),
    .alu_result1(res1_1), .alu_result2(res2_1), .alu_equal(eq1), .alu_greater(gt1),
    .alu_lesser(lt1), .alu_result4(res4_1),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_op(rsp_op1),
    .rsp_data(rsp_data1), .rsp_flags(rsp_flags1), .busy(busy1),
    .ops_done(ops_done1), .dbg_state(dbg_state1)
  );

  // ---------------- instance 3: SETTLE_CYCLES = 3 ----------------
  logic       rst_n3, cmd_valid3, cmd_ready3, rsp_ready3;
  logic       sel0_3, sel1_3, eq3, gt3, lt3, rsp_valid3, busy3;
  logic [3:0] bit1_3, bit2_3;
  logic [4:0] res1_3, res2_3, res4_3, rsp_data3;
  logic [1:0] rsp_op3;
  logic [2:0] rsp_flags3;
  logic [7:0] ops_done3;
  state_t     dbg_state3;

  assign res1_3 = {1'b0, bit1_3} + {1'b0, bit2_3};
  assign res2_3 = {1'bx, 4'(bit1_3 - bit2_3)};
  assign res4_3 = {1'bx, bit1_3 & bit2_3};
  assign eq3    = (bit1_3 == bit2_3);
  assign gt3    = (bit1_3 >  bit2_3);
  assign lt3    = (bit1_3 <  bit2_3);

  alu_seq_ctrl #(.SETTLE_CYCLES(3), .CNT_W(8)) u_dut3 (
    .clk(clk), .rst_n(rst_n3), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_select0(sel0_3), .alu_select1(sel1_3), .alu_bit1(bit1_3), .alu_bit2(bit2_3),
    .alu_result1(res1_3), .alu_result2(res2_3), .alu_equal(eq3), .alu_greater(gt3),
    .alu_lesser(lt3), .alu_result4(res4_3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_op(rsp_op3),
    .rsp_data(rsp_data3), .rsp_flags(rsp_flags3), .busy(busy3),
    .ops_done(ops_done3), .dbg_state(dbg_state3)
  );

  // Reference response straight from the arithmetic definition of each op.
  function automatic logic [9:0] model(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    logic [4:0] d;
    logic [2:0] f;
    d = 5'd0;
    f = 3'b000;
    case (op)
      OP_ADD: d = {1'b0, a} + {1'b0, b};
      OP_SUB: begin d[3:0] = a - b; d[4] = (a < b); end
      OP_CMP: f = (a == b) ? 3'b100 : ((a > b) ? 3'b010 : 3'b001);
      default: d = {1'b0, a & b};
    endcase
    return {op, d, f};
  endfunction

  // ---------------- driver tasks (instance 1) ----------------
  task automatic run_op(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    logic [9:0] exp, got;
    int n;
    exp_q.push_back(model(op, a, b));
    @(negedge clk);
    if (cmd_ready1 !== 1'b1) begin
      n_fail++; $display("FAIL cmd_ready_idle: got %b want 1", cmd_ready1);
    end
    n_checks++;
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_valid1 = 1'b1;
    @(negedge clk);
    cmd_valid1 = 1'b0;
    if ({sel1_1, sel0_1, bit1_1, bit2_1} !== {op, a, b}) begin
      n_fail++; $display("FAIL alu_drive: got %h want %h", {sel1_1, sel0_1, bit1_1, bit2_1}, {op, a, b});
    end
    n_checks++;
    n = 0;
    while (rsp_valid1 !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n != 1) begin
      n_fail++; $display("FAIL latency: got %0d cycles want 1", n);
    end
    n_checks++;
    if ({sel1_1, sel0_1, bit1_1, bit2_1} !== 10'd0) begin
      n_fail++; $display("FAIL alu_park: got %h want 0", {sel1_1, sel0_1, bit1_1, bit2_1});
    end
    n_checks++;
    exp = exp_q.pop_front();
    got = {rsp_op1, rsp_data1, rsp_flags1};
    if (got !== exp) begin
      n_fail++; $display("FAIL rsp op=%0d a=%0d b=%0d: got %b want %b", op, a, b, got, exp);
    end
    n_checks++;
    rsp_ready1 = 1'b1;
    @(negedge clk);
    rsp_ready1 = 1'b0;
    exp_ops1 = exp_ops1 + 8'd1;
    if (rsp_valid1 !== 1'b0 || ops_done1 !== exp_ops1) begin
      n_fail++; $display("FAIL rsp_handshake: valid=%b ops=%0d want valid=0 ops=%0d", rsp_valid1, ops_done1, exp_ops1);
    end
    n_checks++;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n1 = 1'b0; rst_n3 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n1 = 1'b1; rst_n3 = 1'b1;
    exp_ops1 = 8'd0; exp_ops3 = 8'd0;
    if ({cmd_ready1, busy1, rsp_valid1, rsp_op1, rsp_data1, rsp_flags1, ops_done1} !== {1'b1, 20'd0}) begin
      n_fail++; $display("FAIL reset_dut1: got %h", {cmd_ready1, busy1, rsp_valid1, rsp_op1, rsp_data1, rsp_flags1, ops_done1});
    end
    n_checks++;
    if ({sel1_1, sel0_1, bit1_1, bit2_1, dbg_state1} !== 12'd0) begin
      n_fail++; $display("FAIL reset_drive: got %h want 0", {sel1_1, sel0_1, bit1_1, bit2_1, dbg_state1});
    end
    n_checks++;
    if ({cmd_ready3, rsp_valid3, ops_done3} !== {1'b1, 9'd0}) begin
      n_fail++; $display("FAIL reset_dut3: got %h", {cmd_ready3, rsp_valid3, ops_done3});
    end
    n_checks++;
  endtask

  task automatic test_add();
    run_op(OP_ADD, 4'd9, 4'd8);
  endtask

  task automatic test_sub();
    run_op(OP_SUB, 4'd3, 4'd5);
    run_op(OP_SUB, 4'd7, 4'd2);
  endtask

  task automatic test_cmp();
    run_op(OP_CMP, 4'd6, 4'd6);
    run_op(OP_CMP, 4'd2, 4'd9);
    run_op(OP_CMP, 4'd12, 4'd4);
  endtask

  task automatic test_and();
    run_op(OP_AND, 4'hC, 4'hA);
    run_op(OP_AND, 4'hF, 4'hF);
  endtask

  task automatic test_backpressure();
    logic [9:0] snap, exp;
    int n;
    exp_q.push_back(model(OP_SUB, 4'd10, 4'd3));
    @(negedge clk);
    cmd_op = OP_SUB; cmd_a = 4'd10; cmd_b = 4'd3; cmd_valid1 = 1'b1;
    @(negedge clk);
    cmd_valid1 = 1'b0;
    n = 0;
    while (rsp_valid1 !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    snap = {rsp_op1, rsp_data1, rsp_flags1};
    // A competing command is offered while the response is stalled.
    cmd_op = OP_AND; cmd_a = 4'hF; cmd_b = 4'hF; cmd_valid1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if ({rsp_valid1, cmd_ready1, rsp_op1, rsp_data1, rsp_flags1} !== {2'b10, snap}) begin
        n_fail++; $display("FAIL bp_hold cyc%0d: got %b want %b", i, {rsp_valid1, cmd_ready1, rsp_op1, rsp_data1, rsp_flags1}, {2'b10, snap});
      end
      n_checks++;
    end
    exp = exp_q.pop_front();
    if (snap !== exp) begin
      n_fail++; $display("FAIL bp_rsp: got %b want %b", snap, exp);
    end
    n_checks++;
    cmd_valid1 = 1'b0;
    rsp_ready1 = 1'b1;
    @(negedge clk);
    rsp_ready1 = 1'b0;
    exp_ops1 = exp_ops1 + 8'd1;
    if ({rsp_valid1, cmd_ready1, busy1, ops_done1} !== {3'b010, exp_ops1}) begin
      n_fail++; $display("FAIL bp_release: got %h want %h", {rsp_valid1, cmd_ready1, busy1, ops_done1}, {3'b010, exp_ops1});
    end
    n_checks++;
    @(negedge clk);
    if ({busy1, rsp_data1, rsp_flags1} !== {1'b0, exp[7:0]}) begin
      n_fail++; $display("FAIL bp_no_accept: got %h want %h", {busy1, rsp_data1, rsp_flags1}, {1'b0, exp[7:0]});
    end
    n_checks++;
  endtask

  task automatic test_wrap();
    rst_n1 = 1'b0;
    @(negedge clk);
    rst_n1 = 1'b1;
    exp_ops1 = 8'd0;
    for (int i = 0; i < 256; i++)
      run_op(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    if (ops_done1 !== 8'd0) begin
      n_fail++; $display("FAIL ops_wrap: got %0d want 0", ops_done1);
    end
    n_checks++;
  endtask

  task automatic test_settle3();
    logic [9:0] exp;
    int n;
    exp = model(OP_ADD, 4'd15, 4'd15);
    @(negedge clk);
    cmd_op = OP_ADD; cmd_a = 4'd15; cmd_b = 4'd15; cmd_valid3 = 1'b1;
    @(negedge clk);
    cmd_valid3 = 1'b0;
    n = 0;
    while (rsp_valid3 !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n != 3 || {rsp_op3, rsp_data3, rsp_flags3} !== exp) begin
      n_fail++; $display("FAIL settle3_rsp: lat=%0d got %b want lat=3 %b", n, {rsp_op3, rsp_data3, rsp_flags3}, exp);
    end
    n_checks++;
    rsp_ready3 = 1'b1;
    @(negedge clk);
    rsp_ready3 = 1'b0;
    if (ops_done3 !== 8'd1) begin
      n_fail++; $display("FAIL settle3_ops: got %0d want 1", ops_done3);
    end
    n_checks++;
    // Second op is reset during its second settle cycle.
    cmd_op = OP_AND; cmd_a = 4'd6; cmd_b = 4'd7; cmd_valid3 = 1'b1;
    @(negedge clk);
    cmd_valid3 = 1'b0;
    @(negedge clk);
    if ({busy3, bit1_3, bit2_3} !== {1'b1, 4'd6, 4'd7}) begin
      n_fail++; $display("FAIL settle3_midop: got %h want %h", {busy3, bit1_3, bit2_3}, {1'b1, 4'd6, 4'd7});
    end
    n_checks++;
    rst_n3 = 1'b0;
    @(negedge clk);
    rst_n3 = 1'b1;
    if ({dbg_state3, rsp_valid3, sel1_3, sel0_3, bit1_3, bit2_3, ops_done3, rsp_data3} !== 24'd0) begin
      n_fail++; $display("FAIL settle3_reset: got %h want 0", {dbg_state3, rsp_valid3, sel1_3, sel0_3, bit1_3, bit2_3, ops_done3, rsp_data3});
    end
    n_checks++;
    repeat (4) @(negedge clk);
    if ({rsp_valid3, cmd_ready3} !== 2'b01) begin
      n_fail++; $display("FAIL settle3_dropped: got %b want 01", {rsp_valid3, cmd_ready3});
    end
    n_checks++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    cmd_valid1 = 1'b0; cmd_valid3 = 1'b0;
    rsp_ready1 = 1'b0; rsp_ready3 = 1'b0;
    cmd_op = 2'b00; cmd_a = 4'd0; cmd_b = 4'd0;
    rst_n1 = 1'b0; rst_n3 = 1'b0;
    exp_ops1 = 8'd0; exp_ops3 = 8'd0;
    test_reset();
    test_add();
    test_sub();
    test_cmp();
    test_and();
    test_backpressure();
    test_settle3();
    test_wrap();
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: %0d left want 0", exp_q.size());
    end
    n_checks++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
